// File: rtl/gray_counter_bank.sv
// gray_counter_bank: bank of independent Gray-code up/down counters
// with per-channel load, wrap/limit flags and a coherent snapshot.
module gray_counter_bank #(
    parameter int width    = 10,
    parameter int channels = 4,
    parameter int saturate = 0,
    parameter int CW       = (channels > 1) ? $clog2(channels) : 1
) (
    input  logic                      CLK,
    input  logic                      nRST,
    input  logic [channels-1:0]       increment__ENA,
    output logic [channels-1:0]       increment__RDY,
    input  logic [channels-1:0]       decrement__ENA,
    output logic [channels-1:0]       decrement__RDY,
    input  logic                      writeBin__ENA,
    input  logic [CW-1:0]             writeBin__chan,
    input  logic [width-1:0]          writeBin__v,
    output logic                      writeBin__RDY,
    input  logic                      capture__ENA,
    output logic                      capture__RDY,
    output logic [channels*width-1:0] readGray,
    output logic [channels*width-1:0] readBin,
    output logic [channels*width-1:0] readSnap,
    output logic [channels-1:0]       wrapped,
    output logic [channels-1:0]       atMax,
    output logic [channels-1:0]       atMin
);

    localparam logic [width-1:0] MAX_V = {width{1'b1}};
    localparam logic [width-1:0] ONE_V = width'(1);
    localparam bit               SAT   = (saturate != 0);

    assign writeBin__RDY = 1'b1;
    assign capture__RDY  = 1'b1;

    for (genvar c = 0; c < channels; c++) begin : g_ch
        logic [width-1:0] bin_q;
        logic [width-1:0] gray_q;
        logic [width-1:0] snap_q;
        logic             wrap_q;
        logic [width-1:0] bin_d;
        logic [width-1:0] gray_d;
        logic             wrap_d;
        logic             at_max;
        logic             at_min;
        logic             inc_rdy;
        logic             dec_rdy;
        logic             wr_hit;
        logic             step_up;
        logic             step_dn;

        assign at_max = (bin_q == MAX_V);
        assign at_min = (bin_q == '0);

        always_comb begin
            inc_rdy = 1'b1;
            dec_rdy = 1'b1;
            if (SAT) begin
                inc_rdy = !at_max;
                dec_rdy = !at_min;
            end
        end

        assign wr_hit = writeBin__ENA && (writeBin__chan == CW'(c));

        always_comb begin
            step_up = 1'b0;
            step_dn = 1'b0;
            if (!wr_hit) begin
                step_up = increment__ENA[c] && inc_rdy
                       && !(decrement__ENA[c] && dec_rdy);
                step_dn = decrement__ENA[c] && dec_rdy
                       && !(increment__ENA[c] && inc_rdy);
            end
        end

        always_comb begin
            bin_d  = bin_q;
            wrap_d = 1'b0;
            unique case (1'b1)
                wr_hit: begin
                    bin_d = writeBin__v;
                end
                step_up: begin
                    bin_d  = bin_q + ONE_V;
                    wrap_d = !SAT && at_max;
                end
                step_dn: begin
                    bin_d  = bin_q - ONE_V;
                    wrap_d = !SAT && at_min;
                end
                default: begin
                    bin_d = bin_q;
                end
            endcase
            gray_d = bin_d ^ (bin_d >> 1);
        end

        always_ff @(posedge CLK or negedge nRST) begin
            if (!nRST) begin
                bin_q  <= '0;
                gray_q <= '0;
                wrap_q <= 1'b0;
            end else begin
                bin_q  <= bin_d;
                gray_q <= gray_d;
                wrap_q <= wrap_d;
            end
        end

        always_ff @(posedge CLK or negedge nRST) begin
            if (!nRST) begin
                snap_q <= '0;
            end else if (capture__ENA) begin
                snap_q <= gray_q;
            end
        end

        assign increment__RDY[c]            = inc_rdy;
        assign decrement__RDY[c]            = dec_rdy;
        assign atMax[c]                     = at_max;
        assign atMin[c]                     = at_min;
        assign wrapped[c]                   = wrap_q;
        assign readGray[c*width +: width]   = gray_q;
        assign readBin[c*width +: width]    = bin_q;
        assign readSnap[c*width +: width]   = snap_q;
    end

endmodule

// File: tb/tb_gray_counter_bank.sv
// tb_gray_counter_bank: wrap-mode and saturate-mode banks driven by
// directed and random stimulus against an integer reference model.
module tb_gray_counter_bank;

    localparam int WA = 4;
    localparam int NA = 4;
    localparam int WB = 5;
    localparam int NB = 5;

    logic CLK = 1'b0;
    logic nRST;

    logic [NA-1:0]    inc_a, dec_a, irdy_a, drdy_a;
    logic [NA-1:0]    wrp_a, amax_a, amin_a;
    logic             we_a, cap_a, wrdy_a, crdy_a;
    logic [1:0]       ch_a;
    logic [WA-1:0]    v_a;
    logic [NA*WA-1:0] rg_a, rb_a, rs_a;

    logic [NB-1:0]    inc_b, dec_b, irdy_b, drdy_b;
    logic [NB-1:0]    wrp_b, amax_b, amin_b;
    logic             we_b, cap_b, wrdy_b, crdy_b;
    logic [2:0]       ch_b;
    logic [WB-1:0]    v_b;
    logic [NB*WB-1:0] rg_b, rb_b, rs_b;

    int vectors = 0;
    int miscompares = 0;

    int mb[2][16];
    int ms[2][16];
    int mw[2][16];

    always #5 CLK = ~CLK;

    gray_counter_bank #(.width(WA), .channels(NA), .saturate(0)) u_a (
        .CLK(CLK), .nRST(nRST),
        .increment__ENA(inc_a), .increment__RDY(irdy_a),
        .decrement__ENA(dec_a), .decrement__RDY(drdy_a),
        .writeBin__ENA(we_a), .writeBin__chan(ch_a),
        .writeBin__v(v_a), .writeBin__RDY(wrdy_a),
        .capture__ENA(cap_a), .capture__RDY(crdy_a),
        .readGray(rg_a), .readBin(rb_a), .readSnap(rs_a),
        .wrapped(wrp_a), .atMax(amax_a), .atMin(amin_a)
    );

    gray_counter_bank #(.width(WB), .channels(NB), .saturate(1)) u_b (
        .CLK(CLK), .nRST(nRST),
        .increment__ENA(inc_b), .increment__RDY(irdy_b),
        .decrement__ENA(dec_b), .decrement__RDY(drdy_b),
        .writeBin__ENA(we_b), .writeBin__chan(ch_b),
        .writeBin__v(v_b), .writeBin__RDY(wrdy_b),
        .capture__ENA(cap_b), .capture__RDY(crdy_b),
        .readGray(rg_b), .readBin(rb_b), .readSnap(rs_b),
        .wrapped(wrp_b), .atMax(amax_b), .atMin(amin_b)
    );

    function automatic int gry(int x);
        return x ^ (x >> 1);
    endfunction

    function automatic int wof(int u);
        return (u != 0) ? WB : WA;
    endfunction

    function automatic int nof(int u);
        return (u != 0) ? NB : NA;
    endfunction

    function automatic int topv(int u);
        return (1 << wof(u)) - 1;
    endfunction

    function automatic logic [79:0] pk(int u, int k);
        logic [79:0] r;
        int x;
        r = '0;
        for (int c = 0; c < nof(u); c++) begin
            if (k == 0) x = mb[u][c];
            else if (k == 1) x = gry(mb[u][c]);
            else x = ms[u][c];
            r = r | (80'(x) << (c * wof(u)));
        end
        return r;
    endfunction

    function automatic logic [15:0] fl(int u, int k);
        logic [15:0] r;
        r = '0;
        for (int c = 0; c < nof(u); c++) begin
            case (k)
                0: r[c] = (mw[u][c] != 0);
                1: r[c] = (mb[u][c] == topv(u));
                2: r[c] = (mb[u][c] == 0);
                3: r[c] = (u == 0) || (mb[u][c] != topv(u));
                default: r[c] = (u == 0) || (mb[u][c] != 0);
            endcase
        end
        return r;
    endfunction

    task automatic chk(string tag, logic [79:0] got, logic [79:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic mreset();
        for (int u = 0; u < 2; u++)
            for (int c = 0; c < 16; c++) begin
                mb[u][c] = 0;
                ms[u][c] = 0;
                mw[u][c] = 0;
            end
    endtask

    task automatic mstep(int u, logic [15:0] inc, logic [15:0] dec,
                         logic we, int ch, int v, logic cap);
        for (int c = 0; c < nof(u); c++) begin
            mw[u][c] = 0;
            if (cap) ms[u][c] = gry(mb[u][c]);
            if (we && ch == c) begin
                mb[u][c] = v;
            end else if (inc[c] && !dec[c]) begin
                if (mb[u][c] < topv(u)) mb[u][c]++;
                else if (u == 0) begin
                    mb[u][c] = 0;
                    mw[u][c] = 1;
                end
            end else if (dec[c] && !inc[c]) begin
                if (mb[u][c] > 0) mb[u][c]--;
                else if (u == 0) begin
                    mb[u][c] = topv(u);
                    mw[u][c] = 1;
                end
            end
        end
    endtask

    task automatic check_all();
        chk("a.bin", 80'(rb_a), pk(0, 0));
        chk("a.gray", 80'(rg_a), pk(0, 1));
        chk("a.snap", 80'(rs_a), pk(0, 2));
        chk("a.wrap", 80'(wrp_a), 80'(fl(0, 0)));
        chk("a.max", 80'(amax_a), 80'(fl(0, 1)));
        chk("a.min", 80'(amin_a), 80'(fl(0, 2)));
        chk("a.irdy", 80'(irdy_a), 80'(fl(0, 3)));
        chk("a.drdy", 80'(drdy_a), 80'(fl(0, 4)));
        chk("a.wrdy", 80'(wrdy_a & crdy_a), 80'(1));
        chk("b.bin", 80'(rb_b), pk(1, 0));
        chk("b.gray", 80'(rg_b), pk(1, 1));
        chk("b.snap", 80'(rs_b), pk(1, 2));
        chk("b.wrap", 80'(wrp_b), 80'(fl(1, 0)));
        chk("b.max", 80'(amax_b), 80'(fl(1, 1)));
        chk("b.min", 80'(amin_b), 80'(fl(1, 2)));
        chk("b.irdy", 80'(irdy_b), 80'(fl(1, 3)));
        chk("b.drdy", 80'(drdy_b), 80'(fl(1, 4)));
        chk("b.wrdy", 80'(wrdy_b & crdy_b), 80'(1));
    endtask

    task automatic idle();
        inc_a = '0; dec_a = '0; we_a = 1'b0; cap_a = 1'b0;
        ch_a = '0; v_a = '0;
        inc_b = '0; dec_b = '0; we_b = 1'b0; cap_b = 1'b0;
        ch_b = '0; v_b = '0;
    endtask

    task automatic step();
        logic [NA*WA-1:0] pa;
        logic [NB*WB-1:0] pb;
        logic [15:0] m;
        logic act;
        m = fl(1, 3);
        inc_b = inc_b & m[NB-1:0];
        m = fl(1, 4);
        dec_b = dec_b & m[NB-1:0];
        pa = rg_a;
        pb = rg_b;
        act = nRST;
        if (act) begin
            mstep(0, 16'(inc_a), 16'(dec_a), we_a, int'(ch_a),
                  int'(v_a), cap_a);
            mstep(1, 16'(inc_b), 16'(dec_b), we_b, int'(ch_b),
                  int'(v_b), cap_b);
        end
        @(posedge CLK);
        #1;
        check_all();
        if (act) begin
            for (int c = 0; c < NA; c++)
                if (!(we_a && int'(ch_a) == c))
                    chk("a.ham", 80'($countones(
                        pa[c*WA +: WA] ^ rg_a[c*WA +: WA]) <= 1), 80'(1));
            for (int c = 0; c < NB; c++)
                if (!(we_b && int'(ch_b) == c))
                    chk("b.ham", 80'($countones(
                        pb[c*WB +: WB] ^ rg_b[c*WB +: WB]) <= 1), 80'(1));
        end
    endtask

    initial begin
        idle();
        mreset();
        nRST = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check_all();
        chk("rst.min", 80'(amin_a), 80'(4'hf));
        chk("rst.drdy_b", 80'(drdy_b), 80'(0));
        nRST = 1'b1;

        inc_a = 4'b0001;
        repeat (5) step();
        chk("t1.bin0", 80'(rb_a[3:0]), 80'(5));
        chk("t1.gray0", 80'(rg_a[3:0]), 80'(4'b0111));
        chk("t1.others", 80'(rb_a[15:4]), 80'(0));

        idle(); we_a = 1'b1; ch_a = 2'd2; v_a = 4'd15;
        step();
        chk("t2.gray15", 80'(rg_a[11:8]), 80'(4'b1000));
        idle(); inc_a = 4'b0100;
        step();
        chk("t2.bin2", 80'(rb_a[11:8]), 80'(0));
        chk("t2.gray2", 80'(rg_a[11:8]), 80'(0));
        chk("t2.wrap2", 80'(wrp_a[2]), 80'(1));
        idle();
        step();
        chk("t2.wrapoff", 80'(wrp_a[2]), 80'(0));

        idle(); we_b = 1'b1; ch_b = 3'd1; v_b = 5'd31;
        step();
        chk("t3.irdy1", 80'(irdy_b[1]), 80'(0));
        chk("t3.max1", 80'(amax_b[1]), 80'(1));
        idle(); dec_b = 5'b00010;
        step();
        chk("t3.bin1", 80'(rb_b[9:5]), 80'(30));
        chk("t3.irdy1b", 80'(irdy_b[1]), 80'(1));

        idle(); we_a = 1'b1; ch_a = 2'd3; v_a = 4'd15;
        step();
        idle(); inc_a = 4'b1000; dec_a = 4'b1000;
        step();
        chk("t4.incdec", 80'(rb_a[15:12]), 80'(15));
        idle(); inc_a = 4'b1000; we_a = 1'b1; ch_a = 2'd3; v_a = 4'd9;
        step();
        chk("t4.wrwins", 80'(rb_a[15:12]), 80'(9));
        chk("t4.nowrap", 80'(wrp_a[3]), 80'(0));
        idle(); we_b = 1'b1; ch_b = 3'd7; v_b = 5'd17;
        step();
        chk("t4.oor7", 80'(rb_b), 80'(30 << 5));
        idle(); we_b = 1'b1; ch_b = 3'd5; v_b = 5'd3;
        step();
        chk("t4.oor5", 80'(rb_b), 80'(30 << 5));

        for (int c = 0; c < 4; c++) begin
            idle(); we_a = 1'b1; ch_a = 2'(c); v_a = 4'(3 * (c + 1));
            step();
        end
        idle(); cap_a = 1'b1; inc_a = 4'hf;
        step();
        chk("t5.snap", 80'(rs_a), 80'(16'had52));
        chk("t5.gray", 80'(rg_a), 80'(16'hbf46));
        idle(); inc_a = 4'hf;
        step();
        chk("t5.hold", 80'(rs_a), 80'(16'had52));

        idle(); inc_a = 4'h1; inc_b = 5'h1;
        repeat (3) step();
        #2 nRST = 1'b0;
        #1;
        mreset();
        check_all();
        chk("t6.bin", 80'(rb_a), 80'(0));
        chk("t6.min", 80'(amin_a), 80'(4'hf));
        chk("t6.drdy", 80'(drdy_b), 80'(0));
        step();
        nRST = 1'b1;
        step();
        chk("t6.resume", 80'(rb_a[3:0]), 80'(1));

        for (int i = 0; i < 10000; i++) begin
            inc_a = 4'($urandom);
            dec_a = 4'($urandom);
            we_a = ($urandom_range(7) == 0);
            ch_a = 2'($urandom);
            v_a = 4'($urandom);
            cap_a = ($urandom_range(7) == 0);
            inc_b = 5'($urandom);
            dec_b = 5'($urandom);
            we_b = ($urandom_range(5) == 0);
            ch_b = 3'($urandom_range(7));
            v_b = ($urandom_range(3) == 0) ? 5'd31 : 5'($urandom);
            cap_b = ($urandom_range(7) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
